// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared command codes, widths and FSM encoding for lcd_host.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    localparam int c_CMD_W  = 4;
    localparam int c_PIX_AW = 6;
    localparam int c_PIX_DW = 8;
    localparam int c_SUM_W  = 14;
    localparam int c_CNT_W  = 7;
    localparam int c_NPIX   = 64;

    typedef logic [c_CMD_W-1:0] cmd_t;

    localparam cmd_t c_CMD_WRITE    = 4'h0;
    localparam cmd_t c_CMD_SHIFT_U  = 4'h1;
    localparam cmd_t c_CMD_SHIFT_D  = 4'h2;
    localparam cmd_t c_CMD_SHIFT_L  = 4'h3;
    localparam cmd_t c_CMD_SHIFT_R  = 4'h4;
    localparam cmd_t c_CMD_MAX      = 4'h5;
    localparam cmd_t c_CMD_MIN      = 4'h6;
    localparam cmd_t c_CMD_AVG      = 4'h7;
    localparam cmd_t c_CMD_ROT_CCW  = 4'h8;
    localparam cmd_t c_CMD_ROT_CW   = 4'h9;
    localparam cmd_t c_CMD_MIRROR_X = 4'hA;
    localparam cmd_t c_CMD_MIRROR_Y = 4'hB;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        ISSUE     = 3'd2,
        GAP       = 3'd3,
        WAIT_BUSY = 3'd4,
        CAPTURE   = 3'd5,
        FINISH    = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lcd_host_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_host_if
// Description : Script ROM, LCD controller command and image-write bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_host_if
    import lcd_pkg::*;
#(
    parameter int CMDROM_AW = 5
);
    logic [CMDROM_AW-1:0] CMDROM_A;
    logic [c_CMD_W-1:0]   CMDROM_Q;
    logic [c_CMD_W-1:0]   cmd;
    logic                 cmd_valid;
    logic                 busy;
    logic                 IRAM_valid;
    logic [c_PIX_AW-1:0]  IRAM_A;
    logic [c_PIX_DW-1:0]  IRAM_D;
    logic                 done;
    logic [c_SUM_W-1:0]   result_sum;
    logic [c_CNT_W-1:0]   pix_cnt;
    logic                 finished;
    logic                 error;

    modport master (
        output CMDROM_A, cmd, cmd_valid, result_sum, pix_cnt, finished, error,
        input  CMDROM_Q, busy, IRAM_valid, IRAM_A, IRAM_D, done
    );

    modport slave (
        input  CMDROM_A, cmd, cmd_valid, result_sum, pix_cnt, finished, error,
        output CMDROM_Q, busy, IRAM_valid, IRAM_A, IRAM_D, done
    );
endinterface
`default_nettype wire

// File: rtl/iram_capture.sv
`default_nettype none
// ============================================================================
// Module      : iram_capture
// Description : First-write-wins pixel capture: mask, running sum, count.
// Revision    : 1.0 - initial release
// ============================================================================
module iram_capture
    import lcd_pkg::*;
(
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic                i_clear,
    input  wire logic                i_cap_en,
    input  wire logic [c_PIX_AW-1:0] i_addr,
    input  wire logic [c_PIX_DW-1:0] i_data,
    output logic      [c_SUM_W-1:0]  o_result_sum,
    output logic      [c_CNT_W-1:0]  o_pix_cnt,
    output logic      [c_CNT_W-1:0]  o_pix_cnt_next
);

    logic [c_NPIX-1:0]  r_mask;
    logic [c_SUM_W-1:0] r_sum;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_new;

    assign w_new          = i_cap_en && !r_mask[i_addr];
    // Count including a write landing this cycle, so done can judge completeness.
    assign o_pix_cnt_next = r_cnt + c_CNT_W'(w_new);
    assign o_result_sum   = r_sum;
    assign o_pix_cnt      = r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mask <= '0;
            r_sum  <= '0;
            r_cnt  <= '0;
        end else if (i_clear) begin
            r_mask <= '0;
            r_sum  <= '0;
            r_cnt  <= '0;
        end else if (w_new) begin
            r_mask[i_addr] <= 1'b1;
            r_sum          <= r_sum + c_SUM_W'(i_data);
            r_cnt          <= o_pix_cnt_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lcd_host.sv
`default_nettype none
// ============================================================================
// Module      : lcd_host
// Description : Runs a command script on an LCD controller and sums the image.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_host
    import lcd_pkg::*;
#(
    parameter int TIMEOUT   = 1024,
    parameter int CMDROM_AW = 5
)(
    input wire logic    clk,
    input wire logic    reset,
    input wire logic    start,
    lcd_host_if.master  bus
);

    localparam int                   c_TW        = $clog2(TIMEOUT + 1);
    localparam logic [CMDROM_AW-1:0] c_LAST_ADDR = '1;

    state_t               r_state;
    state_t               w_next;
    logic [CMDROM_AW-1:0] r_addr;
    cmd_t                 r_cmd;
    logic                 r_error;
    logic [c_TW-1:0]      r_tmo;

    logic                 w_tmo_hit;
    logic                 w_cmd_valid;
    logic                 w_clear;
    logic                 w_cap_en;
    logic                 w_err_set;
    logic [c_SUM_W-1:0]   w_sum;
    logic [c_CNT_W-1:0]   w_pix_cnt;
    logic [c_CNT_W-1:0]   w_cnt_next;

    assign w_tmo_hit = (r_tmo == c_TW'(TIMEOUT - 1));
    assign w_cap_en  = (r_state == CAPTURE) && bus.IRAM_valid;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_cmd_valid = 1'b0;
        w_clear     = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            IDLE, FINISH: begin
                if (start) begin
                    w_next  = FETCH;
                    w_clear = 1'b1;
                end
            end
            FETCH: begin
                w_err_set = bus.IRAM_valid;
                w_next    = ISSUE;
            end
            ISSUE: begin
                w_err_set = bus.IRAM_valid;
                if (!bus.busy) begin
                    w_cmd_valid = 1'b1;
                    w_next      = (r_cmd == c_CMD_WRITE) ? CAPTURE : GAP;
                end else if (w_tmo_hit) begin
                    w_next    = FINISH;
                    w_err_set = 1'b1;
                end
            end
            GAP: begin
                w_err_set = bus.IRAM_valid;
                w_next    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                w_err_set = bus.IRAM_valid;
                if (!bus.busy) begin
                    w_next = FETCH;
                end else if (w_tmo_hit) begin
                    w_next    = FINISH;
                    w_err_set = 1'b1;
                end
            end
            CAPTURE: begin
                if (bus.done) begin
                    w_next    = FINISH;
                    w_err_set = (w_cnt_next != c_CNT_W'(c_NPIX));
                end else if (w_tmo_hit) begin
                    w_next    = FINISH;
                    w_err_set = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_addr  <= '0;
            r_cmd   <= c_CMD_WRITE;
            r_error <= 1'b0;
            r_tmo   <= '0;
        end else begin
            // Timer restarts on every state change and only runs in wait states.
            if (w_next != r_state || !(r_state inside {ISSUE, WAIT_BUSY, CAPTURE}))
                r_tmo <= '0;
            else
                r_tmo <= r_tmo + c_TW'(1);

            if (w_clear)        r_error <= 1'b0;
            else if (w_err_set) r_error <= 1'b1;

            if (w_clear)
                r_addr <= '0;
            else if (r_state == GAP)
                r_addr <= r_addr + CMDROM_AW'(1);

            // The last script slot always becomes the write command.
            if (r_state == FETCH)
                r_cmd <= (r_addr == c_LAST_ADDR) ? c_CMD_WRITE : bus.CMDROM_Q;
        end
    end

    iram_capture u_capture (
        .clk            (clk),
        .reset          (reset),
        .i_clear        (w_clear),
        .i_cap_en       (w_cap_en),
        .i_addr         (bus.IRAM_A),
        .i_data         (bus.IRAM_D),
        .o_result_sum   (w_sum),
        .o_pix_cnt      (w_pix_cnt),
        .o_pix_cnt_next (w_cnt_next)
    );

    assign bus.CMDROM_A   = r_addr;
    assign bus.cmd        = r_cmd;
    assign bus.cmd_valid  = w_cmd_valid;
    assign bus.result_sum = w_sum;
    assign bus.pix_cnt    = w_pix_cnt;
    assign bus.finished   = (r_state == FINISH);
    assign bus.error      = r_error;

endmodule
`default_nettype wire

// File: doc/lcd_host.md
LCD_HOST -- requirements
Module: lcd_host

Interface
REQ-001 Parameter TIMEOUT, 1024, max cycles waited in any wait state before abort.
REQ-002 Parameter CMDROM_AW, 5, command-script address width (32 entries).
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse; begins a script run.
REQ-006 CMDROM_A  out  CMDROM_AW  script address.
REQ-007 CMDROM_Q  in  4  command code at CMDROM_A, combinational (same-cycle) read.
REQ-008 cmd  out  4  command to LCD controller.
REQ-009 cmd_valid  out  1  command strobe.
REQ-010 busy  in  1  controller busy; a command is accepted only while busy=0.
REQ-011 IRAM_valid  in  1  controller write strobe.
REQ-012 IRAM_A  in  6  write address.
REQ-013 IRAM_D  in  8  write data.
REQ-014 done  in  1  controller completion flag.
REQ-015 result_sum  out  14  sum of the 64 captured pixels (max 16320, no overflow).
REQ-016 pix_cnt  out  7  number of distinct addresses captured (0..64).
REQ-017 finished  out  1  run complete; held until next start.
REQ-018 error  out  1  sticky protocol/timeout error for current run.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, ISSUE, GAP, WAIT_BUSY, CAPTURE, FINISH.
REQ-020 IDLE/FINISH: start=1 -> FETCH, clearing CMDROM_A, result_sum, pix_cnt, capture mask, error, finished; start in other states SHALL be ignored.
REQ-021 FETCH: register CMDROM_Q into cmd; address 2**CMDROM_AW-1 SHALL be forced to cmd=0 (write); -> ISSUE.
REQ-022 ISSUE: when busy=0 assert cmd_valid for exactly one cycle, then -> GAP if cmd!=0, -> CAPTURE if cmd=0; while busy=1 remain, cmd_valid=0.
REQ-023 GAP: one cycle, cmd_valid=0 (covers controller's one-cycle busy rise latency); CMDROM_A increments; -> WAIT_BUSY.
REQ-024 WAIT_BUSY: busy=0 -> FETCH; so each non-write command costs min 4 cycles.
REQ-025 cmd SHALL hold its value from FETCH until next FETCH; cmd_valid=0 outside ISSUE.
REQ-026 CAPTURE: on IRAM_valid=1 with mask[IRAM_A]=0, add IRAM_D to result_sum, set mask bit, pix_cnt+1; writes to an already-set address ignored (repeated address-63 writes legal).
REQ-027 CAPTURE: done=1 -> FINISH; write in the same cycle counted first; error set if resulting pix_cnt!=64.
REQ-028 IRAM_valid=1 in FETCH/ISSUE/GAP/WAIT_BUSY SHALL set error, data not captured.
REQ-029 Timeout counter clears on every state entry and counts in ISSUE, WAIT_BUSY, CAPTURE; reaching TIMEOUT -> FINISH with error=1.
REQ-030 FINISH: finished=1, all outputs held.

Reset
REQ-031 reset=0 at a clock edge SHALL force IDLE, cmd=0, cmd_valid=0, CMDROM_A=0, result_sum=0, pix_cnt=0, mask=0, finished=0, error=0, timeout=0, mid-run included; no run resumes.

Structure
REQ-032 Shared package lcd_pkg SHALL hold the 4-bit command codes (0 write, 1-4 shift U/D/L/R, 5 max, 6 min, 7 avg, 8 CCW, 9 CW, A mirror-x, B mirror-y) and the state encoding.
REQ-033 One sub-module iram_capture SHALL implement mask, result_sum, pix_cnt (clear, capture enable inputs).

Verification
REQ-034 Script [0], controller model writes 64 pixels value 1 then done -> finished=1, result_sum=64, pix_cnt=64, error=0.
REQ-035 Script [1,5,0], busy high 3 cycles per command -> exactly 3 cmd_valid pulses, each while busy=0, order 1,5,0.
REQ-036 Writes addresses 0..62 once and 63 five times with 0xFF -> pix_cnt=64, result_sum=16320, error=0.
REQ-037 done after 40 writes -> finished=1, pix_cnt=40, error=1.
REQ-038 busy stuck high after first command, TIMEOUT=16 -> FINISH within 16 cycles, error=1; IRAM_valid during WAIT_BUSY -> error=1.
REQ-039 reset=0 while in CAPTURE after 10 writes -> next cycle all outputs zero, state IDLE; new start runs cleanly.
